// File: rtl/proc_pkg.sv
// Shared definitions for the processor pipeline: default widths, the NOP word
// and the IF/ID skid-stage state encoding.
package proc_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF    = 4;
    localparam int CNT_W_DEF   = 8;

    // addi x0, x0, 0 -- the canonical RISC-V NOP presented to ID on bubbles
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

endpackage

// File: rtl/if_id_entry.sv
// One IF/ID holding slot: a valid flag plus the {instr, next_instr, next_pc}
// payload. Clear wins over load so a flush always empties the slot.
module if_id_entry
    import proc_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] dInstr,
    input  logic [INSTR_W-1:0] dNextInstr,
    input  logic [PC_W-1:0]    dNextPc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] nextInstr,
    output logic [PC_W-1:0]    nextPc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload only changes on an actual write; validity is tracked separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr     <= '0;
            nextInstr <= '0;
            nextPc    <= '0;
        end else if (load) begin
            instr     <= dInstr;
            nextInstr <= dNextInstr;
            nextPc    <= dNextPc;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID boundary with a two-entry skid buffer so if_ready comes
// straight from a register; adds flush, NOP injection and a stall counter.
module if_id_skid_reg
    import proc_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter int                 CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [INSTR_W-1:0] if_next_instr,
    input  logic [PC_W-1:0]    if_next_pc,
    input  logic               flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_next_instr,
    output logic [PC_W-1:0]    id_next_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic               inXfer;
    logic               outXfer;
    logic               mLoad, mClear, sLoad, sClear, mFromSkid;
    logic               mValid, sValid;
    logic [INSTR_W-1:0] mInstr, mNextInstr, sInstr, sNextInstr;
    logic [INSTR_W-1:0] mDInstr, mDNextInstr;
    logic [PC_W-1:0]    mNextPc, sNextPc, mDNextPc;

    assign if_ready = (state != ST_SKID);
    assign inXfer   = if_valid & if_ready;
    assign outXfer  = mValid & id_ready;

    // Next-state and slot write enables; flush overrides every transfer.
    always_comb begin
        stateNext = state;
        mLoad     = 1'b0;
        mClear    = 1'b0;
        sLoad     = 1'b0;
        sClear    = 1'b0;
        mFromSkid = 1'b0;
        if (flush) begin
            stateNext = ST_EMPTY;
            mClear    = 1'b1;
            sClear    = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (inXfer) begin
                        mLoad     = 1'b1;
                        stateNext = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (inXfer && outXfer) begin
                        mLoad = 1'b1;
                    end else if (inXfer) begin
                        sLoad     = 1'b1;
                        stateNext = ST_SKID;
                    end else if (outXfer) begin
                        mClear    = 1'b1;
                        stateNext = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (outXfer) begin
                        mLoad     = 1'b1;
                        mFromSkid = sValid;
                        sClear    = 1'b1;
                        stateNext = ST_FULL;
                    end
                end
                default: stateNext = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    assign mDInstr     = mFromSkid ? sInstr     : if_instr;
    assign mDNextInstr = mFromSkid ? sNextInstr : if_next_instr;
    assign mDNextPc    = mFromSkid ? sNextPc    : if_next_pc;

    if_id_entry #(.INSTR_W(INSTR_W), .PC_W(PC_W)) mainEntry (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mLoad),
        .clear      (mClear),
        .dInstr     (mDInstr),
        .dNextInstr (mDNextInstr),
        .dNextPc    (mDNextPc),
        .valid      (mValid),
        .instr      (mInstr),
        .nextInstr  (mNextInstr),
        .nextPc     (mNextPc)
    );

    if_id_entry #(.INSTR_W(INSTR_W), .PC_W(PC_W)) skidEntry (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sLoad),
        .clear      (sClear),
        .dInstr     (if_instr),
        .dNextInstr (if_next_instr),
        .dNextPc    (if_next_pc),
        .valid      (sValid),
        .instr      (sInstr),
        .nextInstr  (sNextInstr),
        .nextPc     (sNextPc)
    );

    assign id_valid      = mValid;
    assign id_instr      = mValid ? mInstr     : NOP_INSTR;
    assign id_next_instr = mValid ? mNextInstr : NOP_INSTR;
    assign id_next_pc    = mValid ? mNextPc    : '0;

    // Saturating count of cycles where ID is offered a word but refuses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (mValid && !id_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for the IF/ID skid stage: reset, streaming, skid, flush,
// simultaneous transfers and stall-counter saturation (CNT_W=4).
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [68:0] EMPTY_BUS = {1'b0, NOP, NOP, 4'h0};

    localparam logic [67:0] WA = {32'h0A0A_0A0A, 32'h0B0B_0B0B, 4'h1};
    localparam logic [67:0] WB = {32'h1B1B_1B1B, 32'h2B2B_2B2B, 4'h2};
    localparam logic [67:0] WC = {32'hC0C0_C0C0, 32'hC1C1_C1C1, 4'h3};
    localparam logic [67:0] WD = {32'hD0D0_D0D0, 32'hD1D1_D1D1, 4'h4};
    localparam logic [67:0] WE = {32'hE0E0_E0E0, 32'hE1E1_E1E1, 4'h9};
    localparam logic [67:0] WF = {32'hF0F0_F0F0, 32'hF1F1_F1F1, 4'hA};
    localparam logic [67:0] WG = {32'h1234_5678, 32'h9ABC_DEF0, 4'hB};

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_next_instr;
    logic [3:0]  if_next_pc;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_next_instr;
    logic [3:0]  id_next_pc;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    if_id_skid_reg #(
        .INSTR_W   (32),
        .PC_W      (4),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_next_instr (if_next_instr),
        .if_next_pc    (if_next_pc),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_next_instr (id_next_instr),
        .id_next_pc    (id_next_pc),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [68:0] idBus();
        return {id_valid, id_instr, id_next_instr, id_next_pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [67:0] w);
        if_valid = 1'b1;
        {if_instr, if_next_instr, if_next_pc} = w;
    endtask

    task automatic idle();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (idBus() !== EMPTY_BUS || if_ready !== 1'b1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial got bus=%h rdy=%b cnt=%0d want bus=%h rdy=1 cnt=0", idBus(), if_ready, stall_cnt, EMPTY_BUS);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        id_ready = 1'b0;
        push(WA);
        tick();
        push(WB);
        tick();
        idle();
        checks++;
        if (idBus() !== {1'b1, WA} || if_ready !== 1'b0 || stall_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL reset_prefill got bus=%h rdy=%b cnt=%0d want bus=%h rdy=0 cnt=1", idBus(), if_ready, stall_cnt, {1'b1, WA});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (idBus() !== EMPTY_BUS || if_ready !== 1'b1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_async got bus=%h rdy=%b cnt=%0d want bus=%h rdy=1 cnt=0", idBus(), if_ready, stall_cnt, EMPTY_BUS);
        end
        #1 rst_n = 1'b1;
        push(WC);
        tick();
        checks++;
        if (idBus() !== {1'b1, WC}) begin
            errors++;
            $display("[TB] FAIL reset_first_accept got %h want %h", idBus(), {1'b1, WC});
        end
        idle();
        id_ready = 1'b1;
        tick();
        checks++;
        if (idBus() !== EMPTY_BUS || stall_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_drain got bus=%h cnt=%0d want bus=%h cnt=0", idBus(), stall_cnt, EMPTY_BUS);
        end
    endtask

    task automatic test_streaming();
        logic [67:0] ws [4];
        ws[0] = {32'hAAAA_AAAA, 32'h5555_5555, 4'h5};
        ws[1] = {32'h1111_1111, 32'h2222_2222, 4'h6};
        ws[2] = {32'h3333_3333, 32'h4444_4444, 4'h7};
        ws[3] = {32'hDEAD_BEEF, 32'hCAFE_F00D, 4'h8};
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(ws[i]);
            tick();
            checks++;
            if (idBus() !== {1'b1, ws[i]} || if_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_word%0d got bus=%h rdy=%b want bus=%h rdy=1", i, idBus(), if_ready, {1'b1, ws[i]});
            end
        end
        idle();
        tick();
        checks++;
        if (idBus() !== EMPTY_BUS) begin
            errors++;
            $display("[TB] FAIL stream_tail got %h want %h", idBus(), EMPTY_BUS);
        end
    endtask

    task automatic test_skid();
        id_ready = 1'b0;
        push(WA);
        tick();
        checks++;
        if (idBus() !== {1'b1, WA} || if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skid_first got bus=%h rdy=%b want bus=%h rdy=1", idBus(), if_ready, {1'b1, WA});
        end
        push(WB);
        tick();
        idle();
        checks++;
        if (idBus() !== {1'b1, WA} || if_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skid_hold got bus=%h rdy=%b want bus=%h rdy=0", idBus(), if_ready, {1'b1, WA});
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (idBus() !== {1'b1, WB} || if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skid_release got bus=%h rdy=%b want bus=%h rdy=1", idBus(), if_ready, {1'b1, WB});
        end
        tick();
        checks++;
        if (idBus() !== EMPTY_BUS || stall_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL skid_drain got bus=%h cnt=%0d want bus=%h cnt=1", idBus(), stall_cnt, EMPTY_BUS);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        push(WA);
        tick();
        push(WB);
        tick();
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_setup if_ready got %b want 0", if_ready);
        end
        push(WC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++;
        if (idBus() !== EMPTY_BUS || if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_empty got bus=%h rdy=%b want bus=%h rdy=1", idBus(), if_ready, EMPTY_BUS);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (idBus() !== EMPTY_BUS) begin
                errors++;
                $display("[TB] FAIL flush_no_ghost%0d got %h want %h", i, idBus(), EMPTY_BUS);
            end
        end
        checks++;
        if (stall_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL flush_cnt got %0d want 3", stall_cnt);
        end
    endtask

    task automatic test_simultaneous();
        id_ready = 1'b1;
        push(WD);
        tick();
        push(WE);
        tick();
        checks++;
        if (idBus() !== {1'b1, WE} || if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_replace got bus=%h rdy=%b want bus=%h rdy=1", idBus(), if_ready, {1'b1, WE});
        end
        push(WF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++;
        if (idBus() !== EMPTY_BUS || if_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_flush got bus=%h rdy=%b want bus=%h rdy=1", idBus(), if_ready, EMPTY_BUS);
        end
        tick();
        checks++;
        if (idBus() !== EMPTY_BUS || stall_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL simul_after got bus=%h cnt=%0d want bus=%h cnt=3", idBus(), stall_cnt, EMPTY_BUS);
        end
    endtask

    task automatic test_counter();
        id_ready = 1'b0;
        push(WG);
        tick();
        idle();
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 4'd8 || idBus() !== {1'b1, WG}) begin
            errors++;
            $display("[TB] FAIL cnt_partial got cnt=%0d bus=%h want cnt=8 bus=%h", stall_cnt, idBus(), {1'b1, WG});
        end
        repeat (15) tick();
        checks++;
        if (stall_cnt !== 4'd15 || idBus() !== {1'b1, WG}) begin
            errors++;
            $display("[TB] FAIL cnt_saturate got cnt=%0d bus=%h want cnt=15 bus=%h", stall_cnt, idBus(), {1'b1, WG});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 4'd15 || idBus() !== EMPTY_BUS) begin
            errors++;
            $display("[TB] FAIL cnt_flush got cnt=%0d bus=%h want cnt=15 bus=%h", stall_cnt, idBus(), EMPTY_BUS);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL cnt_hold got %0d want 15", stall_cnt);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        if_valid      = 1'b0;
        if_instr      = '0;
        if_next_instr = '0;
        if_next_pc    = '0;
        flush         = 1'b0;
        id_ready      = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_simultaneous();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
